// File: rtl/button_event_pkg.sv
// Shared types for the button event scheduler: per-channel press states and
// the record stored in the event queue.
package button_event_pkg;

   localparam int MAX_BTN_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG_HELD
   } chanState_e;

   typedef struct packed {
      logic [MAX_BTN_W-1:0] btn;
      logic                 isLong;
   } evtRec_t;

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: synchronizer, debouncer and short/long press
// classifier. Raises a one-cycle event strobe with its kind.
module btn_channel
   import button_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 2_000_000,
   parameter int LONG_PRESS_CYCLES = 100_000_000
) (
   input  logic clock_100mhz,
   input  logic reset,
   input  logic btnRaw_i,
   output logic evtRaise_o,
   output logic evtLong_o
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW  = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   logic           sync1_q, sync2_q;
   logic           db_q, db_d;
   logic [DBW-1:0] dbCnt_q, dbCnt_d;
   logic [HW-1:0]  hold_q, hold_d;
   chanState_e     state_q, state_d;

   // Any cycle where the synchronized level matches the debounced one
   // restarts the stability count.
   always_comb begin
      dbCnt_d = '0;
      db_d    = db_q;
      if (sync2_q != db_q) begin
         if (dbCnt_q == DB_LAST) begin
            db_d = sync2_q;
         end else begin
            dbCnt_d = dbCnt_q + 1'b1;
         end
      end
   end

   // A release wins over reaching the long threshold in the same cycle.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      evtRaise_o = 1'b0;
      evtLong_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (db_q) begin
               state_d = PRESSED;
               hold_d  = '0;
            end
         end
         PRESSED: begin
            if (!db_q) begin
               state_d    = IDLE;
               evtRaise_o = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d    = LONG_HELD;
               evtRaise_o = 1'b1;
               evtLong_o  = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         LONG_HELD: begin
            if (!db_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_100mhz) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         dbCnt_q <= '0;
         hold_q  <= '0;
         state_q <= IDLE;
      end else begin
         sync1_q <= btnRaw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         dbCnt_q <= dbCnt_d;
         hold_q  <= hold_d;
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounced multi-button event source: per-channel pending slots drained by a
// round-robin arbiter into a small event FIFO with a valid/ready output.
module button_event_scheduler
   import button_event_pkg::*;
#(
   parameter int NUM_BTN           = 5,
   parameter int DEBOUNCE_CYCLES   = 2_000_000,
   parameter int LONG_PRESS_CYCLES = 100_000_000,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                       clock_100mhz,
   input  logic                       reset,
   input  logic [NUM_BTN-1:0]         btn_raw,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [$clog2(NUM_BTN)-1:0] evt_btn,
   output logic                       evt_long,
   output logic                       overflow
);

   localparam int BW = $clog2(NUM_BTN);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [NUM_BTN-1:0] raise, raiseLong;
   logic [NUM_BTN-1:0] pendValid_q, pendValid_d;
   logic [NUM_BTN-1:0] pendLong_q, pendLong_d;
   logic [NUM_BTN-1:0] grant;
   logic [BW-1:0]      rrPtr_q, rrPtr_d, grantIdx;
   logic               anyPend, push, pop, full;
   logic               overflow_q, overflow_d;
   evtRec_t            mem_q [FIFO_DEPTH];
   evtRec_t            pushRec, head;
   logic [PW-1:0]      wrPtr_q, rdPtr_q;
   logic [PW:0]        count_q, count_d;
   logic [MAX_BTN_W-1:0] unusedHeadBits;

   for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
      btn_channel #(
         .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
      ) uChan (
         .clock_100mhz(clock_100mhz),
         .reset       (reset),
         .btnRaw_i    (btn_raw[i]),
         .evtRaise_o  (raise[i]),
         .evtLong_o   (raiseLong[i])
      );
   end

   assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
   assign evt_valid = (count_q != '0);
   assign pop       = evt_valid && evt_ready;

   // Search starts at the channel after the last grant and wraps once.
   always_comb begin
      int idx;
      idx      = 0;
      grant    = '0;
      grantIdx = '0;
      anyPend  = 1'b0;
      for (int k = 0; k < NUM_BTN; k++) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= NUM_BTN) idx = idx - NUM_BTN;
         if (!anyPend && pendValid_q[idx]) begin
            anyPend  = 1'b1;
            grantIdx = BW'(idx);
         end
      end
      push = anyPend && !full;
      if (push) grant[grantIdx] = 1'b1;
      rrPtr_d = rrPtr_q;
      if (push) rrPtr_d = (grantIdx == BW'(NUM_BTN - 1)) ? '0 : grantIdx + 1'b1;
      pushRec.btn    = MAX_BTN_W'(grantIdx);
      pushRec.isLong = pendLong_q[grantIdx];
   end

   // A slot that is still occupied this cycle refuses a new event, even if
   // it is being granted in the same cycle.
   always_comb begin
      pendValid_d = pendValid_q & ~grant;
      pendLong_d  = pendLong_q;
      overflow_d  = overflow_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (raise[i]) begin
            if (pendValid_q[i]) begin
               overflow_d = 1'b1;
            end else begin
               pendValid_d[i] = 1'b1;
               pendLong_d[i]  = raiseLong[i];
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_100mhz) begin
      if (reset) begin
         pendValid_q <= '0;
         pendLong_q  <= '0;
         rrPtr_q     <= '0;
         overflow_q  <= 1'b0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
      end else begin
         pendValid_q <= pendValid_d;
         pendLong_q  <= pendLong_d;
         rrPtr_q     <= rrPtr_d;
         overflow_q  <= overflow_d;
         count_q     <= count_d;
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clock_100mhz) begin
      if (push) mem_q[wrPtr_q] <= pushRec;
   end

   // Storage is not reset, so the head is masked while the queue is empty.
   assign head           = mem_q[rdPtr_q];
   assign unusedHeadBits = head.btn;
   assign evt_btn        = evt_valid ? head.btn[BW-1:0] : '0;
   assign evt_long       = evt_valid & head.isLong;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench: directed press scenarios with literal expectations plus
// randomized button activity compared every cycle against a behavioural model.
module tb_button_event_scheduler;

   localparam int NB = 5;
   localparam int DB = 4;
   localparam int LP = 20;
   localparam int FD = 4;

   typedef struct {
      int btn;
      bit isLong;
   } evt_t;

   typedef struct {
      int cyc;
      int btn;
      int isLong;
   } logEnt_t;

   logic          clock_100mhz;
   logic          reset;
   logic [NB-1:0] btnRaw;
   logic          evtValid;
   logic          evtReady;
   logic [2:0]    evtBtn;
   logic          evtLong;
   logic          overflowFlag;

   int checkCount = 0;
   int passCount  = 0;
   int cyc        = 0;
   bit modelLive  = 0;

   bit   mS1[NB], mS2[NB], mDb[NB];
   int   mRun[NB], mAge[NB];
   bit   mInPress[NB], mLongSent[NB];
   bit   mPend[NB], mPendLong[NB];
   int   mRr;
   bit   mOvf;
   evt_t mQ[$];

   int   gnt;
   bit   doPop, newPend;
   bit   rse[NB], rseLong[NB];
   evt_t pushRec;

   logEnt_t logQ[$];

   button_event_scheduler #(
      .NUM_BTN          (NB),
      .DEBOUNCE_CYCLES  (DB),
      .LONG_PRESS_CYCLES(LP),
      .FIFO_DEPTH       (FD)
   ) dut (
      .clock_100mhz(clock_100mhz),
      .reset       (reset),
      .btn_raw     (btnRaw),
      .evt_valid   (evtValid),
      .evt_ready   (evtReady),
      .evt_btn     (evtBtn),
      .evt_long    (evtLong),
      .overflow    (overflowFlag)
   );

   initial begin
      clock_100mhz = 1'b0;
      forever #5 clock_100mhz = ~clock_100mhz;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clock_100mhz);
         #1;
      end
   endtask

   task automatic applyStimulus(input int cycles, input int maxDur, input int readyPct);
      int remain[NB];
      for (int i = 0; i < NB; i++) remain[i] = $urandom_range(1, maxDur);
      repeat (cycles) begin
         for (int i = 0; i < NB; i++) begin
            if (remain[i] == 0) begin
               btnRaw[i] = ~btnRaw[i];
               remain[i] = $urandom_range(1, maxDur);
            end else begin
               remain[i]--;
            end
         end
         evtReady = ($urandom_range(0, 99) < readyPct);
         stepCycles(1);
      end
   endtask

   // Behavioural reference: sync is a two-sample delay, a level is accepted
   // after DB differing samples, and a press is tracked by its age.
   always @(posedge clock_100mhz) begin
      cyc++;
      if (reset) begin
         for (int i = 0; i < NB; i++) begin
            mS1[i] = 0; mS2[i] = 0; mDb[i] = 0; mRun[i] = 0; mAge[i] = 0;
            mInPress[i] = 0; mLongSent[i] = 0; mPend[i] = 0; mPendLong[i] = 0;
         end
         mQ.delete();
         mRr = 0;
         mOvf = 0;
         modelLive = 1;
      end else begin
         doPop = (mQ.size() != 0) && evtReady;
         gnt = -1;
         if (mQ.size() < FD) begin
            for (int k = 0; k < NB; k++) begin
               if (gnt < 0 && mPend[(mRr + k) % NB]) gnt = (mRr + k) % NB;
            end
         end
         for (int i = 0; i < NB; i++) begin
            rse[i] = 0;
            rseLong[i] = 0;
            if (!mInPress[i]) begin
               if (mDb[i]) begin
                  mInPress[i] = 1; mAge[i] = 0; mLongSent[i] = 0;
               end
            end else if (!mDb[i]) begin
               mInPress[i] = 0;
               if (!mLongSent[i]) rse[i] = 1;
            end else if (!mLongSent[i] && mAge[i] == LP - 1) begin
               mLongSent[i] = 1; rse[i] = 1; rseLong[i] = 1;
            end else begin
               mAge[i]++;
            end
            if (mS2[i] != mDb[i]) begin
               mRun[i]++;
               if (mRun[i] == DB) begin
                  mDb[i] = mS2[i];
                  mRun[i] = 0;
               end
            end else begin
               mRun[i] = 0;
            end
            mS2[i] = mS1[i];
            mS1[i] = btnRaw[i];
         end
         if (doPop) void'(mQ.pop_front());
         if (gnt >= 0) begin
            pushRec.btn = gnt;
            pushRec.isLong = mPendLong[gnt];
            mQ.push_back(pushRec);
            mRr = (gnt + 1) % NB;
         end
         for (int i = 0; i < NB; i++) begin
            if (rse[i] && mPend[i]) mOvf = 1;
            newPend = (mPend[i] && gnt != i) || (rse[i] && !mPend[i]);
            if (rse[i] && !mPend[i]) mPendLong[i] = rseLong[i];
            mPend[i] = newPend;
         end
      end
   end

   always @(negedge clock_100mhz) begin
      logEnt_t ent;
      if (modelLive) begin
         checkOutput("evt_valid", int'(evtValid), (mQ.size() != 0) ? 1 : 0);
         checkOutput("evt_btn", int'(evtBtn), (mQ.size() != 0) ? mQ[0].btn : 0);
         checkOutput("evt_long", int'(evtLong), (mQ.size() != 0) ? int'(mQ[0].isLong) : 0);
         checkOutput("overflow", int'(overflowFlag), int'(mOvf));
         if (evtValid && evtReady) begin
            ent.cyc = cyc;
            ent.btn = int'(evtBtn);
            ent.isLong = int'(evtLong);
            logQ.push_back(ent);
         end
      end
   end

   initial begin
      int base;
      int n;
      bit found;

      reset = 1'b1;
      btnRaw = '0;
      evtReady = 1'b0;
      stepCycles(3);
      checkOutput("reset_valid", int'(evtValid), 0);
      checkOutput("reset_btn", int'(evtBtn), 0);
      checkOutput("reset_long", int'(evtLong), 0);
      checkOutput("reset_overflow", int'(overflowFlag), 0);
      reset = 1'b0;
      evtReady = 1'b1;
      stepCycles(2);
      checkOutput("post_reset_valid", int'(evtValid), 0);

      $display("[TB] short press on button 2");
      base = logQ.size();
      btnRaw[2] = 1'b1;
      stepCycles(10);
      checkOutput("short_quiet_while_held", logQ.size() - base, 0);
      btnRaw[2] = 1'b0;
      stepCycles(30);
      checkOutput("short_count", logQ.size() - base, 1);
      if (logQ.size() > base) begin
         checkOutput("short_btn", logQ[base].btn, 2);
         checkOutput("short_long", logQ[base].isLong, 0);
      end

      $display("[TB] bouncing button 0");
      base = logQ.size();
      for (int t = 0; t < 8; t++) begin
         btnRaw[0] = ~btnRaw[0];
         stepCycles(2);
      end
      btnRaw[0] = 1'b0;
      stepCycles(30);
      checkOutput("bounce_count", logQ.size() - base, 0);

      $display("[TB] long press on button 4");
      base = logQ.size();
      btnRaw[4] = 1'b1;
      stepCycles(40);
      checkOutput("long_count_while_held", logQ.size() - base, 1);
      if (logQ.size() > base) begin
         checkOutput("long_btn", logQ[base].btn, 4);
         checkOutput("long_kind", logQ[base].isLong, 1);
      end
      btnRaw[4] = 1'b0;
      stepCycles(30);
      checkOutput("long_release_count", logQ.size() - base, 1);

      $display("[TB] simultaneous release of buttons 0, 1, 3");
      base = logQ.size();
      btnRaw = 5'b01011;
      stepCycles(8);
      btnRaw = '0;
      stepCycles(30);
      checkOutput("arb_count", logQ.size() - base, 3);
      if (logQ.size() >= base + 3) begin
         checkOutput("arb_first", logQ[base].btn, 0);
         checkOutput("arb_second", logQ[base+1].btn, 1);
         checkOutput("arb_third", logQ[base+2].btn, 3);
         checkOutput("arb_gap1", logQ[base+1].cyc - logQ[base].cyc, 1);
         checkOutput("arb_gap2", logQ[base+2].cyc - logQ[base+1].cyc, 1);
      end

      $display("[TB] backpressure with six presses on button 1");
      base = logQ.size();
      evtReady = 1'b0;
      for (int p = 0; p < 6; p++) begin
         btnRaw[1] = 1'b1;
         stepCycles(8);
         btnRaw[1] = 1'b0;
         stepCycles(12);
      end
      stepCycles(10);
      checkOutput("bp_valid", int'(evtValid), 1);
      checkOutput("bp_overflow", int'(overflowFlag), 1);
      checkOutput("bp_no_pops", logQ.size() - base, 0);
      evtReady = 1'b1;
      stepCycles(20);
      checkOutput("bp_drained", logQ.size() - base, 5);
      for (int e = base; e < logQ.size(); e++) begin
         checkOutput("bp_evt_btn", logQ[e].btn, 1);
         checkOutput("bp_evt_long", logQ[e].isLong, 0);
      end
      checkOutput("bp_overflow_sticky", int'(overflowFlag), 1);
      checkOutput("bp_empty", int'(evtValid), 0);

      reset = 1'b1;
      stepCycles(1);
      checkOutput("rst_valid", int'(evtValid), 0);
      checkOutput("rst_overflow", int'(overflowFlag), 0);
      reset = 1'b0;
      stepCycles(2);
      checkOutput("rst_overflow_after", int'(overflowFlag), 0);

      $display("[TB] reset during a press on button 3");
      base = logQ.size();
      btnRaw[3] = 1'b1;
      stepCycles(17);
      checkOutput("rst_press_quiet", logQ.size() - base, 0);
      reset = 1'b1;
      stepCycles(1);
      reset = 1'b0;
      n = 0;
      found = 0;
      while (!found && n < 100) begin
         stepCycles(1);
         n++;
         if (evtValid) found = 1;
      end
      checkOutput("rst_press_latency", n, 28);
      checkOutput("rst_press_btn", int'(evtBtn), 3);
      checkOutput("rst_press_long", int'(evtLong), 1);
      btnRaw[3] = 1'b0;
      stepCycles(30);
      checkOutput("rst_press_count", logQ.size() - base, 1);

      $display("[TB] randomized activity");
      applyStimulus(1500, 40, 70);
      reset = 1'b1;
      stepCycles(1);
      reset = 1'b0;
      applyStimulus(1500, 12, 40);
      btnRaw = '0;
      evtReady = 1'b1;
      stepCycles(80);
      checkOutput("final_empty", int'(evtValid), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/button_event_scheduler.md
BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

Interface
REQ-001 Parameter NUM_BTN, default 5: number of push-button inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2_000_000: stable-level cycles required to accept a level change (20 ms at 100 MHz).
REQ-003 Parameter LONG_PRESS_CYCLES, default 100_000_000: debounced-high cycles that classify a press as long (1 s).
REQ-004 Parameter FIFO_DEPTH, default 4: event queue depth, a power of two.
REQ-005 Port clock_100mhz, input, 1: sole clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port btn_raw, input, NUM_BTN: asynchronous noisy button levels, 1 = pressed.
REQ-008 Port evt_valid, output, 1: the queue head event is available.
REQ-009 Port evt_ready, input, 1: the consumer accepts the head event when evt_valid && evt_ready.
REQ-010 Port evt_btn, output, clog2(NUM_BTN): index of the button for the head event.
REQ-011 Port evt_long, output, 1: head event kind, 1 = long press, 0 = short press.
REQ-012 Port overflow, output, 1: sticky flag, set when any event is dropped.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any match SHALL restart the count.
REQ-015 Each channel SHALL run an FSM with states IDLE, PRESSED and LONG_HELD.
REQ-016 IDLE->PRESSED SHALL occur on a debounced rise, and the hold counter SHALL clear to 0.
REQ-017 In PRESSED, the hold counter SHALL increment each cycle and saturate.
REQ-018 PRESSED->LONG_HELD SHALL occur when the hold counter reaches LONG_PRESS_CYCLES-1, raising exactly one long event.
REQ-019 PRESSED->IDLE on a debounced fall SHALL raise one short event.
REQ-020 LONG_HELD->IDLE on a debounced fall SHALL raise no event.
REQ-021 A raised event SHALL set that channel's one-deep pending register (button kind) on the next edge.
REQ-022 If an event is raised while that channel's pending register is still set, the new event SHALL be dropped and overflow SHALL be set.
REQ-023 Each cycle the FIFO is not full, a round-robin arbiter SHALL move at most one pending event into the FIFO and clear its pending register.
REQ-024 Arbiter priority SHALL start at the channel after the last granted one; after reset, channel 0 has highest priority.
REQ-025 Push SHALL be blocked when the FIFO is full, even if a pop occurs in the same cycle; pending events wait and are not dropped.
REQ-026 Push and pop in the same cycle on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 evt_valid SHALL equal (count != 0).
REQ-029 evt_btn and evt_long SHALL show the head entry and SHALL hold stable while evt_valid && !evt_ready.
REQ-030 Latency: an event pending set at edge N with the FIFO empty SHALL give evt_valid=1 after edge N+1.

Reset
REQ-031 Reset SHALL clear the following: synchronizers, debounced levels, debounce/hold counters, all FSMs to IDLE, all pending registers, FIFO pointers and count, the round-robin pointer to channel 0, and overflow.
REQ-032 During and after reset, outputs SHALL be evt_valid=0, evt_btn=0, evt_long=0, overflow=0.
REQ-033 Reset asserted mid-press SHALL discard the press; a button held through reset release SHALL be treated as a new press after debounce.

Structure
REQ-034 Package button_event_pkg SHALL hold the channel-state enum (IDLE, PRESSED, LONG_HELD) and the event-record type {btn index, long bit}.
REQ-035 One sub-module, btn_channel, SHALL contain the per-button synchronizer, debouncer, FSM and hold counter, instantiated NUM_BTN times; the arbiter and FIFO SHALL be in the top module.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, FIFO_DEPTH=4, NUM_BTN=5)
REQ-036 Short press: btn 2 high for 10 cycles, glitch-free, with evt_ready=1 -> exactly one event, btn=2, long=0, no events during the press.
REQ-037 Bounce: btn 0 toggled every 2 cycles for 16 cycles, then low -> no event.
REQ-038 Long press: btn 4 held for 40 cycles -> one long event (btn=4, long=1) while the button is still held, and no event on release.
REQ-039 Arbitration: btns 0, 1 and 3 released in the same cycle with evt_ready=1 -> events in order 0, 1, 3 on consecutive cycles.
REQ-040 Backpressure/overflow: evt_ready=0, then 6 short presses on btn 1 -> 4 events queued, 1 pending, the 6th dropped, overflow=1; then evt_ready=1 -> 5 events drained, overflow stays 1 until reset.
REQ-041 Reset mid-press: reset pulsed for 1 cycle at hold count 10 on btn 3, button kept high -> no event until a new debounce completes, then a long event 20 cycles later.
